qspi_master_ctrl: RTL and testbench
===================================

Name: qspi_master_ctrl

Overview:
- Synthesizable SPI/quad-SPI master controller that sequences word and dword transfers over a 1/2/4-lane MOSI/MISO bus with SCLK and CS_N.
- Accepts transfer requests from the on-chip host (crypto accelerator register front-end) through a valid/ready handshake.
- Generates SCLK from the system clock, shifts data LSB-first across the selected lanes and returns captured MISO data.
- Supports burst mode: CS_N stays asserted between consecutive requests.

Parameters:
- HALF_DIV, 2, system clocks per SCLK half-period (legal range 1..255).
- CS_GAP, 2, minimum system clocks CS_N stays high after a non-burst transfer (legal range 1..255).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  transfer request valid
- req_ready  out  1  controller can accept a request this cycle
- req_lanes  in  2  0=1 lane, 1=2 lanes, 2=4 lanes, 3=reserved (treated as 1 lane)
- req_dword  in  1  0=16-bit transfer, 1=32-bit transfer
- req_burst  in  1  1=keep CS_N low after this transfer
- req_data  in  32  TX data, LSB first; bits [31:16] ignored when req_dword=0
- rsp_valid  out  1  one-cycle pulse: transfer complete
- rsp_data  out  32  captured MISO data, zero-extended for 16-bit transfers
- busy  out  1  high from request acceptance until return to IDLE
- mosi  out  4  serial data lanes; unused lanes driven 0
- miso  in  4  serial data lanes from the slave
- sclk  out  1  serial clock, idle low (mode 0)
- cs_n  out  1  chip select, active low

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-low.
- Clock and reset port names are clk and rst_n.
- Reset values: cs_n=1, sclk=0, mosi=0, req_ready=0 for one cycle after reset release (then 1), rsp_valid=0, rsp_data=0, busy=0.
- Request fields are latched when req_valid && req_ready. req_ready=1 only in IDLE after any CS_GAP countdown has expired.
- Transfer size: L = 1/2/4 lanes; W = 16/32 bits; beats N = W/L.
- Beat k drives mosi[j] = data[k*L+j] for j < L; all other lanes are 0.
- Capture: rx[k*L+j] = miso[j] is taken at the clk edge that ends the HIGH phase of beat k, i.e. the edge that drives sclk from 1 to 0.
- All outputs are registered. Phase counter counts HALF_DIV cycles per state.
- FSM states:
  - IDLE: waits for a request. On accept, go to SETUP.
  - SETUP: cs_n=0, sclk=0, beat 0 on mosi, for HALF_DIV cycles. Then go to HIGH.
  - HIGH: sclk=1 for HALF_DIV cycles; MISO captured on the exit edge. If the beat is not the last, go to LOW; otherwise go to HOLD.
  - LOW: sclk=0, next beat on mosi, for HALF_DIV cycles. Then go to HIGH.
  - HOLD: sclk=0, mosi=0, for HALF_DIV cycles. Then pulse rsp_valid and load rsp_data. If burst, go to IDLE with cs_n kept 0. If not burst, go to GAP.
  - GAP: cs_n=1, held for CS_GAP cycles. Then go to IDLE.
- Latency: cs_n falls on the first cycle after acceptance. Transfer lasts (2N+1)*HALF_DIV cycles from cs_n fall to rsp_valid.
- Burst: a request accepted in IDLE while cs_n=0 goes straight to SETUP without toggling cs_n. A following non-burst request closes the frame.
- Lane or width changes between burst requests are legal and take effect at SETUP.
- rsp_valid and acceptance of a new request can occur in the same cycle; that cycle is the IDLE entry after HOLD.
- Reset asserted mid-transfer: all outputs go to reset values immediately and no rsp_valid is produced.
- req_valid while busy is ignored; the host holds it under the valid/ready rule.

Test Plan:
- Reset, then 1 lane, 16-bit, data 0x00A5, HALF_DIV=2, miso[0] looped from mosi[0] -> mosi[0] beats 1,0,1,0,0,1,0,1,0…; 16 sclk pulses; cs_n low 66 cycles; rsp_data=0x000000A5; cs_n high ≥2 cycles before req_ready=1.
- 4 lanes, 32-bit, data 0x1234ABCD, miso=4'hF constant -> mosi beats D,C,B,A,4,3,2,1; 8 sclk pulses; rsp_data=0xFFFFFFFF.
- 2 lanes, 16-bit burst 0xFFFF followed by 1 lane non-burst 0x0001 -> cs_n stays 0 between transfers; two rsp_valid pulses; cs_n rises only after the second HOLD.
- req_lanes=3, 16-bit, data 0x8001 -> behaves as 1 lane: 16 sclk pulses; mosi[3:1]=0 throughout.
- rst_n pulsed low during beat 5 of a 32-bit 1-lane transfer -> cs_n=1, sclk=0, mosi=0 asynchronously; no rsp_valid; next request completes normally.
- req_valid held high back-to-back non-burst -> second request accepted only after CS_GAP high cycles; req_ready=0 while busy.

Source files
------------

// File: rtl/qspi_master_ctrl.sv
// qspi_master_ctrl: mode-0 SPI / quad-SPI master sequencer.
// LSB-first 16/32-bit transfers on 1/2/4 lanes with CS burst.
module qspi_master_ctrl #(
  parameter int unsigned HALF_DIV = 2,
  parameter int unsigned CS_GAP   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_lanes,
  input  logic        req_dword,
  input  logic        req_burst,
  input  logic [31:0] req_data,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        busy,
  output logic [3:0]  mosi,
  input  logic [3:0]  miso,
  output logic        sclk,
  output logic        cs_n
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_HIGH  = 3'd2;
  localparam logic [2:0] ST_LOW   = 3'd3;
  localparam logic [2:0] ST_HOLD  = 3'd4;
  localparam logic [2:0] ST_GAP   = 3'd5;

  localparam logic [7:0] HD_LAST  = 8'(HALF_DIV - 1);
  localparam logic [7:0] GAP_LAST = 8'(CS_GAP - 1);

  logic [2:0]  state;
  logic [7:0]  cnt;
  logic [5:0]  beat;
  logic [1:0]  lw_q;
  logic        dword_q;
  logic        burst_q;
  logic [31:0] tx_q;
  logic [31:0] rx_q;

  logic [1:0]  req_lw;
  logic        accept;
  logic        ph_done;
  logic        gap_done;
  logic [5:0]  last_idx;
  logic        last_beat;
  logic [31:0] tx_nxt;
  logic [31:0] rx_nxt;

  // lane code 0=x1, 1=x2, 2=x4
  function automatic logic [3:0] lane_bits(
    input logic [31:0] d,
    input logic [1:0]  lw
  );
    logic [3:0] r;
    r = 4'h0;
    unique case (1'b1)
      lw == 2'd2: r = d[3:0];
      lw == 2'd1: r = {2'b00, d[1:0]};
      default:    r = {3'b000, d[0]};
    endcase
    return r;
  endfunction

  // request decode, phase timing and beat bookkeeping
  always_comb begin
    req_lw    = (req_lanes == 2'd3) ? 2'd0 : req_lanes;
    accept    = req_valid && req_ready;
    ph_done   = (cnt == HD_LAST);
    gap_done  = (cnt == GAP_LAST);
    last_idx  = ((dword_q ? 6'd32 : 6'd16) >> lw_q) - 6'd1;
    last_beat = (beat == last_idx);
  end

  // next TX word and RX shift for the latched lane width
  always_comb begin
    tx_nxt = tx_q >> 1;
    rx_nxt = {miso[0], rx_q[31:1]};
    unique case (1'b1)
      lw_q == 2'd2: begin
        tx_nxt = tx_q >> 4;
        rx_nxt = {miso, rx_q[31:4]};
      end
      lw_q == 2'd1: begin
        tx_nxt = tx_q >> 2;
        rx_nxt = {miso[1:0], rx_q[31:2]};
      end
      default: ;
    endcase
  end

  // transfer sequencer with registered bus and host outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= 8'd0;
      beat      <= 6'd0;
      lw_q      <= 2'd0;
      dword_q   <= 1'b0;
      burst_q   <= 1'b0;
      tx_q      <= 32'd0;
      rx_q      <= 32'd0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= 32'd0;
      busy      <= 1'b0;
      mosi      <= 4'h0;
      sclk      <= 1'b0;
      cs_n      <= 1'b1;
    end else begin
      rsp_valid <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            state     <= ST_SETUP;
            cnt       <= 8'd0;
            beat      <= 6'd0;
            lw_q      <= req_lw;
            dword_q   <= req_dword;
            burst_q   <= req_burst;
            tx_q      <= req_data;
            mosi      <= lane_bits(req_data, req_lw);
            sclk      <= 1'b0;
            cs_n      <= 1'b0;
            req_ready <= 1'b0;
            busy      <= 1'b1;
          end else begin
            req_ready <= 1'b1;
          end
        end
        ST_SETUP: begin
          if (ph_done) begin
            state <= ST_HIGH;
            cnt   <= 8'd0;
            sclk  <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        ST_HIGH: begin
          if (ph_done) begin
            cnt  <= 8'd0;
            sclk <= 1'b0;
            rx_q <= rx_nxt;
            if (last_beat) begin
              state <= ST_HOLD;
              mosi  <= 4'h0;
            end else begin
              state <= ST_LOW;
              beat  <= beat + 6'd1;
              tx_q  <= tx_nxt;
              mosi  <= lane_bits(tx_nxt, lw_q);
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        ST_LOW: begin
          if (ph_done) begin
            state <= ST_HIGH;
            cnt   <= 8'd0;
            sclk  <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        ST_HOLD: begin
          if (ph_done) begin
            cnt       <= 8'd0;
            rsp_valid <= 1'b1;
            rsp_data  <= dword_q ? rx_q : {16'h0000, rx_q[31:16]};
            if (burst_q) begin
              state     <= ST_IDLE;
              req_ready <= 1'b1;
              busy      <= 1'b0;
            end else begin
              state <= ST_GAP;
              cs_n  <= 1'b1;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        ST_GAP: begin
          if (gap_done) begin
            state     <= ST_IDLE;
            cnt       <= 8'd0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= 8'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_qspi_master_ctrl.sv
// tb_qspi_master_ctrl: directed + random bench for qspi_master_ctrl.
// Timeline model derives expected pins from cycle position in a frame.
module tb_qspi_master_ctrl;

  localparam int HD  = 2;
  localparam int GAP = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_lanes = 2'd0;
  logic        req_dword = 1'b0;
  logic        req_burst = 1'b0;
  logic [31:0] req_data = 32'd0;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        busy;
  logic [3:0]  mosi;
  logic [3:0]  miso_w;
  logic        sclk;
  logic        cs_n;

  logic [3:0]  miso_drv = 4'h0;
  logic        loopback = 1'b0;
  logic        miso_rand = 1'b0;

  assign miso_w = loopback ? {3'b000, mosi[0]} : miso_drv;

  qspi_master_ctrl #(.HALF_DIV(HD), .CS_GAP(GAP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_lanes (req_lanes),
    .req_dword (req_dword),
    .req_burst (req_burst),
    .req_data  (req_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .mosi      (mosi),
    .miso      (miso_w),
    .sclk      (sclk),
    .cs_n      (cs_n)
  );

  initial forever #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail_to(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: timeout, got no event expected one at %0t", nm, $time);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // miso changes just after the rising edge; the model samples it mid-cycle
  logic [3:0] m_miso = 4'h0;
  initial forever begin
    @(posedge clk);
    #2;
    if (miso_rand) miso_drv = 4'($urandom);
  end
  initial forever begin
    @(negedge clk);
    m_miso = miso_w;
  end

  // ---------------- timeline reference model ----------------
  int          m_mode = 0;
  int          m_c = 0;
  int          m_L = 1;
  int          m_N = 16;
  int          m_g = 0;
  logic        m_burst = 1'b0;
  logic [31:0] m_tx = 32'd0;
  logic [31:0] m_rx = 32'd0;
  logic        e_cs_n = 1'b1;
  logic        e_sclk = 1'b0;
  logic [3:0]  e_mosi = 4'h0;
  logic        e_rv = 1'b0;
  logic [31:0] e_rdata = 32'd0;
  logic        e_ready = 1'b0;
  logic        e_busy = 1'b0;

  function automatic logic [3:0] beat_bits(input logic [31:0] d,
                                           input int L, input int k);
    logic [3:0] r;
    r = 4'h0;
    for (int j = 0; j < L; j++) r[j] = d[k*L+j];
    return r;
  endfunction

  task automatic m_reset();
    m_mode  = 0;
    e_cs_n  = 1'b1;
    e_sclk  = 1'b0;
    e_mosi  = 4'h0;
    e_rv    = 1'b0;
    e_rdata = 32'd0;
    e_ready = 1'b0;
    e_busy  = 1'b0;
  endtask

  initial begin
    int p;
    int k;
    int L;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_reset();
      end else begin
        e_rv = 1'b0;
        case (m_mode)
          1: begin
            p = m_c / HD;
            if ((p % 2 == 1) && (m_c % HD == HD - 1)) begin
              k = p / 2;
              for (int j = 0; j < m_L; j++) m_rx[k*m_L+j] = m_miso[j];
            end
            m_c++;
            if (m_c == (2*m_N + 1) * HD) begin
              e_rv    = 1'b1;
              e_rdata = m_rx;
              e_sclk  = 1'b0;
              e_mosi  = 4'h0;
              if (m_burst) begin
                m_mode  = 0;
                e_ready = 1'b1;
                e_busy  = 1'b0;
              end else begin
                m_mode = 2;
                m_g    = 0;
                e_cs_n = 1'b1;
              end
            end else begin
              p = m_c / HD;
              e_sclk = (p % 2 == 1);
              e_mosi = (p == 2*m_N) ? 4'h0 : beat_bits(m_tx, m_L, p / 2);
            end
          end
          2: begin
            m_g++;
            if (m_g == GAP) begin
              m_mode  = 0;
              e_ready = 1'b1;
              e_busy  = 1'b0;
            end
          end
          default: begin
            if (req_valid && e_ready) begin
              L = (req_lanes == 2'd1) ? 2 : (req_lanes == 2'd2) ? 4 : 1;
              m_L     = L;
              m_N     = (req_dword ? 32 : 16) / L;
              m_tx    = req_data;
              m_rx    = 32'd0;
              m_burst = req_burst;
              m_c     = 0;
              m_mode  = 1;
              e_cs_n  = 1'b0;
              e_sclk  = 1'b0;
              e_mosi  = beat_bits(req_data, L, 0);
              e_ready = 1'b0;
              e_busy  = 1'b1;
            end else begin
              e_ready = 1'b1;
            end
          end
        endcase
      end
    end
  end

  // every-cycle compare against the model
  initial forever begin
    @(negedge clk);
    chk("cs_n", {31'd0, cs_n}, {31'd0, e_cs_n});
    chk("sclk", {31'd0, sclk}, {31'd0, e_sclk});
    chk("mosi", {28'd0, mosi}, {28'd0, e_mosi});
    chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, e_rv});
    chk("rsp_data", rsp_data, e_rdata);
    chk("req_ready", {31'd0, req_ready}, {31'd0, e_ready});
    chk("busy", {31'd0, busy}, {31'd0, e_busy});
  end

  // ---------------- pin-level monitor ----------------
  int          pulses = 0;
  int          cslow = 0;
  int          cs_rise = 0;
  int          rsp_cnt = 0;
  int          last_rsp_cyc = 0;
  logic [31:0] last_rsp = 32'd0;
  logic        hi_seen = 1'b0;
  logic        both_seen = 1'b0;
  logic        prev_sclk = 1'b0;
  logic        prev_cs = 1'b1;
  logic [3:0]  beats[$];
  logic [31:0] rsp_dq[$];
  logic        rsp_cs[$];

  initial forever begin
    @(negedge clk);
    if (sclk && !prev_sclk) begin
      pulses++;
      beats.push_back(mosi);
    end
    prev_sclk = sclk;
    if (!cs_n) cslow++;
    if (cs_n && !prev_cs) cs_rise++;
    prev_cs = cs_n;
    if (|mosi[3:1]) hi_seen = 1'b1;
    if (busy && req_ready) both_seen = 1'b1;
    if (rsp_valid) begin
      rsp_cnt++;
      last_rsp = rsp_data;
      last_rsp_cyc = cyc;
      rsp_dq.push_back(rsp_data);
      rsp_cs.push_back(cs_n);
    end
  end

  task automatic clr();
    pulses  = 0;
    cslow   = 0;
    cs_rise = 0;
    rsp_cnt = 0;
    hi_seen = 1'b0;
    beats.delete();
    rsp_dq.delete();
    rsp_cs.delete();
  endtask

  function automatic logic [31:0] pack(input int L);
    logic [31:0] r;
    r = 32'd0;
    for (int k = 0; k < beats.size(); k++)
      for (int j = 0; j < L; j++)
        if (k*L + j < 32) r[k*L+j] = beats[k][j];
    return r;
  endfunction

  task automatic issue(input logic [1:0] ln, input logic dw, input logic bu,
                       input logic [31:0] d, output int acc);
    int n;
    @(negedge clk);
    #1;
    req_lanes = ln;
    req_dword = dw;
    req_burst = bu;
    req_data  = d;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 400) begin
      @(negedge clk);
      #1;
      n++;
    end
    acc = cyc;
    if (!req_ready) fail_to("accept");
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int target);
    int n;
    n = 0;
    while (rsp_cnt < target && n < 1000) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (rsp_cnt < target) fail_to("rsp_wait");
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int acc;
    int r0;
    int rc;
    int n;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    #1;
    chk("rst_ready_low", {31'd0, req_ready}, 32'd0);
    chk("rst_cs_n", {31'd0, cs_n}, 32'd1);
    chk("rst_rsp_data", rsp_data, 32'd0);
    @(negedge clk);
    #1;
    chk("rst_ready_high", {31'd0, req_ready}, 32'd1);

    // x1 16-bit loopback
    loopback = 1'b1;
    issue(2'd0, 1'b0, 1'b0, 32'h0000_00A5, acc);
    clr();
    wait_rsp(1);
    chk("t1_pulses", 32'(pulses), 32'd16);
    chk("t1_cslow", 32'(cslow), 32'd66);
    chk("t1_beats", pack(1), 32'h0000_00A5);
    chk("t1_rsp", last_rsp, 32'h0000_00A5);
    r0 = last_rsp_cyc;

    // x4 32-bit, miso all ones
    loopback = 1'b0;
    miso_drv = 4'hF;
    issue(2'd2, 1'b1, 1'b0, 32'h1234_ABCD, acc);
    chk("t1_gap", 32'(acc - r0), 32'(GAP));
    clr();
    wait_rsp(1);
    chk("t2_pulses", 32'(pulses), 32'd8);
    chk("t2_beats", pack(4), 32'h1234_ABCD);
    chk("t2_rsp", last_rsp, 32'hFFFF_FFFF);

    // x2 burst then x1 closing transfer
    loopback = 1'b1;
    issue(2'd1, 1'b0, 1'b1, 32'h0000_FFFF, acc);
    clr();
    issue(2'd0, 1'b0, 1'b0, 32'h0000_0001, acc);
    wait_rsp(2);
    chk("t3_rsp_cnt", 32'(rsp_cnt), 32'd2);
    chk("t3_pulses", 32'(pulses), 32'd24);
    chk("t3_cs_rise", 32'(cs_rise), 32'd1);
    if (rsp_dq.size() >= 2) begin
      chk("t3_rsp0", rsp_dq[0], 32'h0000_5555);
      chk("t3_rsp1", rsp_dq[1], 32'h0000_0001);
      chk("t3_cs0", {31'd0, rsp_cs[0]}, 32'd0);
      chk("t3_cs1", {31'd0, rsp_cs[1]}, 32'd1);
    end else begin
      fail_to("t3_rsp_pair");
    end

    // reserved lane code behaves as x1
    issue(2'd3, 1'b0, 1'b0, 32'h0000_8001, acc);
    clr();
    wait_rsp(1);
    chk("t4_pulses", 32'(pulses), 32'd16);
    chk("t4_hi_lanes", {31'd0, hi_seen}, 32'd0);
    chk("t4_beats", pack(1), 32'h0000_8001);
    chk("t4_rsp", last_rsp, 32'h0000_8001);

    // async reset during beat 5 of a 32-bit x1 transfer
    loopback = 1'b0;
    miso_rand = 1'b1;
    issue(2'd0, 1'b1, 1'b0, $urandom, acc);
    clr();
    n = 0;
    while (pulses < 6 && n < 500) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (pulses < 6) fail_to("t5_beat5");
    rc = rsp_cnt;
    #1 rst_n = 1'b0;
    #1;
    chk("t5_cs_n", {31'd0, cs_n}, 32'd1);
    chk("t5_sclk", {31'd0, sclk}, 32'd0);
    chk("t5_mosi", {28'd0, mosi}, 32'd0);
    chk("t5_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (150) @(negedge clk);
    #1;
    chk("t5_no_rsp", 32'(rsp_cnt), 32'(rc));
    loopback = 1'b1;
    issue(2'd0, 1'b0, 1'b0, 32'h0000_5A3C, acc);
    clr();
    wait_rsp(1);
    chk("t5_after", last_rsp, 32'h0000_5A3C);

    // back-to-back non-burst with valid held
    loopback = 1'b0;
    issue(2'd0, 1'b0, 1'b0, $urandom, acc);
    clr();
    issue(2'd2, 1'b1, 1'b0, $urandom, acc);
    chk("t6_gap", 32'(acc - last_rsp_cyc), 32'(GAP));
    chk("t6_first_rsp", 32'(rsp_cnt), 32'd1);
    clr();
    wait_rsp(1);

    // random traffic
    for (int i = 0; i < 40; i++) begin
      issue(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), $urandom, acc);
      if ($urandom_range(0, 1) == 1) begin
        clr();
        wait_rsp(1);
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    issue(2'd0, 1'b0, 1'b0, $urandom, acc);
    clr();
    wait_rsp(1);
    repeat (10) @(negedge clk);
    #1;
    chk("ready_while_busy", {31'd0, both_seen}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
